// File: rtl/video_pkg.sv
// Shared video definitions: pixel width, BT.601-style luma weights and the
// day/night decision state used by the darkening stage.
package video_pkg;

  localparam int PIX_W   = 24;
  localparam int LUMA_KR = 77;
  localparam int LUMA_KG = 150;
  localparam int LUMA_KB = 29;

  typedef enum logic {
    DAY   = 1'b0,
    NIGHT = 1'b1
  } state_e;

  // Weights sum to 256, so the shifted result is exactly 8 bits.
  function automatic logic [7:0] luma(input logic [PIX_W-1:0] pix);
    logic [15:0] sum;
    sum = 16'(LUMA_KR) * 16'(pix[23:16])
        + 16'(LUMA_KG) * 16'(pix[15:8])
        + 16'(LUMA_KB) * 16'(pix[7:0]);
    return sum[15:8];
  endfunction

endpackage

// File: rtl/frame_darkener_if.sv
// Video-in / video-out bundle of the frame darkener, plus debug taps of the
// decision FSM. The stream has no backpressure: every cycle carries a sample.
interface frame_darkener_if;
  import video_pkg::*;

  logic             en_i;
  logic             vs_i;
  logic             hs_i;
  logic             de_i;
  logic [PIX_W-1:0] live_data_i;
  logic [PIX_W-1:0] dly_data_i;

  logic             vs_o;
  logic             hs_o;
  logic             de_o;
  logic [PIX_W-1:0] data_o;
  logic             inv_o;

  state_e           state_o;
  logic [3:0]       votes_o;

  modport master (
    output en_i, vs_i, hs_i, de_i, live_data_i, dly_data_i,
    input  vs_o, hs_o, de_o, data_o, inv_o, state_o, votes_o
  );

  modport slave (
    input  en_i, vs_i, hs_i, de_i, live_data_i, dly_data_i,
    output vs_o, hs_o, de_o, data_o, inv_o, state_o, votes_o
  );

endinterface

// File: rtl/frame_luma_meter.sv
// Per-frame luma statistics of the live stream: saturating sum and pixel count,
// restarted by a one-cycle close pulse that follows each vsync rising edge.
module frame_luma_meter
  import video_pkg::*;
#(
  parameter int CNT_W = 24,
  parameter int ACC_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             vs_i,
  input  logic             de_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic [ACC_W-1:0] acc_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             close_o,
  output logic             valid_o
);

  logic             vs_q;
  logic             close_d, close_q;
  logic [7:0]       y_d, y_q;
  logic             yv_d, yv_q;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [ACC_W:0]   acc_sum;

  always_comb begin
    close_d = vs_i & ~vs_q;
    y_d     = luma(pix_i);
    yv_d    = de_i;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    acc_sum = {1'b0, acc_q} + (ACC_W+1)'(y_q);
    // The pixel registered during the vsync-rise cycle opens the new frame.
    if (close_q) begin
      acc_d = yv_q ? ACC_W'(y_q) : '0;
      cnt_d = CNT_W'(yv_q);
    end else if (yv_q) begin
      acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_q    <= 1'b0;
      close_q <= 1'b0;
      y_q     <= '0;
      yv_q    <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      vs_q    <= vs_i;
      close_q <= close_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc_o   = acc_q;
  assign cnt_o   = cnt_q;
  assign close_o = close_q;
  assign valid_o = (cnt_q != '0);

endmodule

// File: rtl/frame_darkener.sv
// Inverts the delayed frame when the matching live frame was judged bright,
// using threshold hysteresis and a HOLD-frame debounce on the decision.
module frame_darkener
  import video_pkg::*;
#(
  parameter int          CNT_W = 24,
  parameter int          ACC_W = 32,
  parameter logic [7:0]  TH_HI = 8'd144,
  parameter logic [7:0]  TH_LO = 8'd112,
  parameter int unsigned HOLD  = 2
) (
  input logic              clk_i,
  input logic              rst_ni,
  frame_darkener_if.slave  bus
);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             close, valid;

  frame_luma_meter #(
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) u_meter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .vs_i    (bus.vs_i),
    .de_i    (bus.de_i),
    .pix_i   (bus.live_data_i),
    .acc_o   (acc),
    .cnt_o   (cnt),
    .close_o (close),
    .valid_o (valid)
  );

  state_e           state_d, state_q;
  logic [3:0]       votes_d, votes_q;
  logic             bright, dark, agree, inv_d, inv_q;
  logic             vs_q, hs_q, de_q;
  logic [PIX_W-1:0] data_d, data_q;

  // Comparing sum against threshold*count avoids a divider.
  assign bright = acc > ACC_W'(TH_HI) * ACC_W'(cnt);
  assign dark   = acc < ACC_W'(TH_LO) * ACC_W'(cnt);

  always_comb begin
    state_d = state_q;
    votes_d = votes_q;
    agree   = (state_q == DAY) ? bright : dark;
    if (close && valid) begin
      if (!agree) begin
        votes_d = '0;
      end else if (votes_q + 4'd1 == 4'(HOLD)) begin
        votes_d = '0;
        state_d = (state_q == DAY) ? NIGHT : DAY;
      end else begin
        votes_d = votes_q + 4'd1;
      end
    end
    inv_d  = (state_d == NIGHT) & bus.en_i;
    data_d = bus.de_i ? (inv_d ? ~bus.dly_data_i : bus.dly_data_i) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DAY;
      votes_q <= '0;
      inv_q   <= 1'b0;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      de_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      votes_q <= votes_d;
      inv_q   <= inv_d;
      vs_q    <= bus.vs_i;
      hs_q    <= bus.hs_i;
      de_q    <= bus.de_i;
      data_q  <= data_d;
    end
  end

  assign bus.vs_o    = vs_q;
  assign bus.hs_o    = hs_q;
  assign bus.de_o    = de_q;
  assign bus.data_o  = data_q;
  assign bus.inv_o   = inv_q;
  assign bus.state_o = state_q;
  assign bus.votes_o = votes_q;

endmodule

// File: tb/tb_frame_darkener.sv
// Randomized and directed frames against a frame-level average-luma model.
module tb_frame_darkener;

  localparam int TH_HI = 144;
  localparam int TH_LO = 112;
  localparam int HOLD  = 2;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk_i = ~clk_i;

  frame_darkener_if bus ();

  frame_darkener dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_q[$];

  // Frame-level model: running sum/count of live luma, decision and vote streak.
  longint m_sum;
  int     m_cnt;
  bit     m_night, m_prev_vs;
  int     m_votes;
  bit     pend_valid, pend_night;
  int     pend_votes;
  bit     cur_en  = 1'b1;
  bit     rand_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int luma_of(input logic [23:0] p);
    return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
  endfunction

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_night = 0; m_prev_vs = 0; m_votes = 0;
    pend_valid = 0; pend_night = 0; pend_votes = 0;
    exp_q.delete();
  endtask

  task automatic step(input bit vs, input bit hs, input bit de,
                      input logic [23:0] live, input logic [23:0] dly);
    bit          bright, dark, agree;
    logic [23:0] exp_data;
    @(negedge clk_i);
    if (rand_en) cur_en = ($urandom_range(0, 7) != 0);
    bus.en_i = cur_en; bus.vs_i = vs; bus.hs_i = hs; bus.de_i = de;
    bus.live_data_i = live; bus.dly_data_i = dly;
    // A decision taken at frame start becomes visible one cycle later.
    if (pend_valid) begin
      m_night = pend_night; m_votes = pend_votes; pend_valid = 0;
    end
    if (vs && !m_prev_vs) begin
      if (m_cnt > 0) begin
        bright = m_sum > longint'(TH_HI) * m_cnt;
        dark   = m_sum < longint'(TH_LO) * m_cnt;
        agree  = m_night ? dark : bright;
        pend_night = m_night;
        pend_votes = agree ? m_votes + 1 : 0;
        if (pend_votes == HOLD) begin
          pend_night = !m_night; pend_votes = 0;
        end
        pend_valid = 1;
      end
      m_sum = 0; m_cnt = 0;
    end
    if (de) begin
      m_sum += luma_of(live); m_cnt++;
    end
    m_prev_vs = vs;
    exp_data = de ? ((m_night && cur_en) ? ~dly : dly) : 24'h0;
    exp_q.push_back(exp_data);
    @(posedge clk_i); #1;
    exp_data = exp_q.pop_front();
    check("vs_o",   bus.vs_o,   vs);
    check("hs_o",   bus.hs_o,   hs);
    check("de_o",   bus.de_o,   de);
    check("data_o", bus.data_o, exp_data);
    check("inv_o",  bus.inv_o,  m_night && cur_en);
    check("state",  bus.state_o, m_night);
    check("votes",  bus.votes_o, m_votes);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("rst_vs",    bus.vs_o,    0);
    check("rst_hs",    bus.hs_o,    0);
    check("rst_de",    bus.de_o,    0);
    check("rst_data",  bus.data_o,  0);
    check("rst_inv",   bus.inv_o,   0);
    check("rst_state", bus.state_o, 0);
    check("rst_votes", bus.votes_o, 0);
    model_reset();
    @(negedge clk_i);
    bus.vs_i = 0; bus.hs_i = 0; bus.de_i = 0;
    rst_ni = 1'b1;
  endtask

  task automatic frame_head(input bit de_at_vs, input logic [23:0] live);
    step(1, 0, de_at_vs, live, 24'($urandom));
    step(1, 0, 0, 24'h0, 24'($urandom));
    step(0, 0, 0, 24'h0, 24'($urandom));
    step(0, 0, 0, 24'h0, 24'($urandom));
  endtask

  // kind 0: every pixel is fixed_live; kind 1: random frame-level brightness.
  task automatic frame_body(input int kind, input logic [23:0] fixed_live, input bit de_on);
    int          base, g;
    bit          gray;
    logic [23:0] live;
    base = $urandom_range(0, 245);
    gray = ($urandom_range(0, 3) != 0);
    for (int l = 0; l < 2; l++) begin
      step(0, 1, 0, 24'h0, 24'($urandom));
      step(0, 0, 0, 24'h0, 24'($urandom));
      for (int p = 0; p < 4; p++) begin
        g = base + $urandom_range(0, 10);
        if (kind == 0)  live = fixed_live;
        else if (gray)  live = {8'(g), 8'(g), 8'(g)};
        else            live = 24'($urandom);
        step(0, 0, de_on, live, 24'($urandom));
      end
      step(0, 0, 0, 24'h0, 24'($urandom));
    end
  endtask

  task automatic frame(input int kind, input logic [23:0] fixed_live, input bit de_on);
    frame_head(0, 24'h0);
    frame_body(kind, fixed_live, de_on);
  endtask

  initial begin
    bus.en_i = 1; bus.vs_i = 0; bus.hs_i = 0; bus.de_i = 0;
    bus.live_data_i = 0; bus.dly_data_i = 0;
    model_reset();
    do_reset();

    // Two bright frames, then the frame start that judges the second one.
    frame(0, 24'hFFFFFF, 1);
    frame(0, 24'hFFFFFF, 1);
    check("day_before", bus.inv_o, 0);
    frame_head(0, 24'h0);
    check("night_after", bus.inv_o, 1);
    step(0, 0, 1, 24'hFFFFFF, 24'h123456);
    check("inv_pix", bus.data_o, 24'hEDCBA9);
    frame_body(0, 24'hFFFFFF, 1);

    // Band frames never move the decision.
    repeat (3) frame(0, 24'h808080, 1);
    frame_head(0, 24'h0);
    check("band_hold", bus.inv_o, 1);
    check("band_votes", bus.votes_o, 0);
    frame_body(0, 24'h000000, 1);
    frame(0, 24'h808080, 1);
    frame(0, 24'h000000, 1);
    frame(0, 24'h808080, 1);
    frame_head(0, 24'h0);
    check("alt_hold", bus.inv_o, 1);
    frame_body(0, 24'h000000, 1);
    frame(0, 24'h000000, 1);
    frame_head(0, 24'h0);
    check("dark_exit", bus.inv_o, 0);

    // An empty frame casts no vote and keeps the streak.
    frame_body(0, 24'hFFFFFF, 1);
    frame(0, 24'h0, 0);
    frame_head(0, 24'h0);
    check("empty_keep", bus.votes_o, 1);
    check("empty_state", bus.state_o, 0);
    frame_body(0, 24'hFFFFFF, 1);
    frame_head(0, 24'h0);
    check("empty_night", bus.inv_o, 1);
    frame_body(0, 24'h000000, 1);

    // The pixel coincident with vsync rise opens the new frame.
    frame_head(1, 24'hFFFFFF);
    check("vs_pix_prev", bus.votes_o, 1);
    frame_body(0, 24'h0, 0);
    frame_head(0, 24'h0);
    check("vs_pix_new", bus.votes_o, 0);
    check("vs_pix_st", bus.state_o, 1);

    // Enable gating in NIGHT.
    cur_en = 0;
    step(0, 0, 1, 24'h0, 24'hABCDEF);
    check("en_off_pix", bus.data_o, 24'hABCDEF);
    check("en_off_inv", bus.inv_o, 0);
    cur_en = 1;
    step(0, 0, 1, 24'h0, 24'hABCDEF);
    check("en_on_pix", bus.data_o, 24'h543210);
    step(0, 0, 0, 24'h0, 24'hABCDEF);
    check("de_off_pix", bus.data_o, 24'h0);
    frame_body(0, 24'h0, 1);

    // Random frames with sporadic enable drops.
    rand_en = 1;
    repeat (24) frame(1, 24'h0, ($urandom_range(0, 7) != 0));

    // Reset in the middle of a frame.
    frame_head(0, 24'h0);
    step(0, 1, 0, 24'h0, 24'($urandom));
    step(0, 0, 1, 24'hFFFFFF, 24'($urandom));
    do_reset();
    repeat (12) frame(1, 24'h0, 1);
    rand_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_darkener.md
Name: frame_darkener

Overview:
- Post-processing stage directly downstream of the DDR frame delayer; consumes its one-frame-delayed pixel stream.
- Measures average luma of the live input frame (the pixels the delayer is writing).
- At the next frame start, decides with hysteresis and debounce whether that frame is "bright".
- While the delayer plays that same frame back, inverts its pixels (dark mode) or passes them through, with sync signals aligned.

Parameters:
- CNT_W, 24, width of per-frame active-pixel counter; must hold H*V (1920*1080 fits).
- ACC_W, 32, width of luma accumulator; must be at least 8+CNT_W-1 sufficient (1920*1080*255 < 2^29).
- TH_HI, 8'd144, average luma strictly above this votes "bright".
- TH_LO, 8'd112, average luma strictly below this votes "dark"; TH_LO <= TH_HI.
- HOLD, 2, consecutive agreeing frame votes required to switch state (1..15).

Ports:
- clk_i  in  1  pixel clock
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  1 = inversion allowed; 0 = forced pass-through (measurement continues)
- vs_i  in  1  vertical sync, active high; rising edge = frame start
- hs_i  in  1  horizontal sync, passed through
- de_i  in  1  data enable, shared by live and delayed pixels
- live_data_i  in  24  live pixel {R,G,B}, same as the delayer write input
- dly_data_i  in  24  delayed pixel from the delayer read path, valid with de_i
- vs_o  out  1  vs_i delayed 1 cycle
- hs_o  out  1  hs_i delayed 1 cycle
- de_o  out  1  de_i delayed 1 cycle
- data_o  out  24  processed delayed pixel
- inv_o  out  1  current decision (1 = inverting)

Behaviour:
- Reset: vs_o=hs_o=de_o=0, data_o=0, inv_o=0, state DAY, vote counter 0, acc=0, cnt=0, vs_r=0.
- vs_rise = vs_i & ~vs_r. close = vs_rise delayed 1 cycle.
- Luma stage, 1 register: y_r <= (77R+150G+29B)>>8, which is 8-bit and exact with a 16-bit intermediate. yv <= de_i.
- Accumulator:
  - close cycle: acc <= yv ? y_r : 0 and cnt <= yv. The close cycle is the cycle after vs_rise. The pixel sampled in the vs_rise cycle belongs to the new frame.
  - other cycles with yv: acc += y_r, cnt += 1. Both saturate at all-ones and never wrap.
- Vote, combinational in the close cycle, on pre-update acc/cnt:
  - cnt==0: no vote; state and vote counter are unchanged.
  - bright = acc > TH_HI*cnt; dark = acc < TH_LO*cnt. Products are ACC_W wide.
- Decision FSM, updated at the end of the close cycle:
  - DAY: a bright vote increments the vote counter; on reaching HOLD, go to NIGHT and clear the counter. Any other vote clears the counter.
  - NIGHT: the same rule with dark votes, returning to DAY.
  - A vote in the hysteresis band (neither bright nor dark) clears the counter.
- inv_o = (state==NIGHT) & en_i, registered; changes 2 cycles after vs_rise, before any active pixel of the delayed frame.
- Output pipeline, latency 1 from de_i/dly_data_i:
  - data_o <= de_i ? (inv ? ~dly_data_i : dly_data_i) : 24'h0.
  - vs_o/hs_o/de_o are the inputs registered.
- en_i deasserted mid-frame takes effect on the next cycle's output pixel.
- vs_i held high across many cycles is one frame start only.
- Reset mid-frame returns everything to reset values; the first close after reset produces a vote from a partial frame, which is intended.

Decomposition:
- Shared package (video_pkg):
  - luma coefficients 77/150/29
  - PIX_W=24
  - state enum {DAY, NIGHT}
- Sub-module frame_luma_meter: luma register, acc/cnt, close pulse. Outputs acc, cnt, close, valid(cnt!=0).
- Top: vote logic, FSM, output pipeline.

Test Plan:
- Reset then 3 frames (4x2 active) of live 24'hFFFFFF, HOLD=2 -> inv_o rises 2 cycles after the 2nd frame-start following the bright frames, i.e. after two bright votes. Next delayed pixel 24'h123456 outputs 24'hEDCBA9.
- NIGHT, then frames of live 24'h808080 (luma 128, band) -> vote counter cleared, inv_o stays 1 indefinitely.
- NIGHT, alternate dark frame (24'h000000) and band frame -> never 2 consecutive dark votes, inv_o stays 1. Two dark frames -> inv_o falls.
- Frame with de_i never asserted between vs rises -> cnt=0, no state or counter change.
- Pixel with de_i=1 in the same cycle as vs_rise, luma 255, all others 0 in the previous frame -> counted in the new frame: the previous frame votes dark, and the new frame's acc starts at 255, cnt 1.
- NIGHT with en_i=0 -> data_o equals dly_data_i (24'hABCDEF), inv_o=0. Re-assert en_i -> inverted on the next output pixel. de_i=0 -> data_o=0. Sync outputs lag inputs by exactly 1 cycle.
